// File: rtl/proc_control_fsm.sv
// ============================================================================
// Module   : proc_control_fsm
// Purpose  : Control unit for the simple processor. It sequences time steps
//            T0..T3 and drives the bus, register-enable and ALU controls.
// Options  : PROC_EXT_ALU_OPS_EN adds the and/or/xor ALU opcodes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module proc_control_fsm #(
  parameter int n    = 10,
  parameter int NREG = 8
) (
  input  logic            Clock,
  input  logic            reset,
  input  logic            Run,
  input  logic [n-1:0]    IR,
  output logic            IRin,
  output logic [NREG-1:0] Rin,
  output logic [NREG-1:0] Rout,
  output logic            DINout,
  output logic            Gout,
  output logic            Ain,
  output logic            Gin,
  output logic [2:0]      AluOp,
  output logic            Done,
  output logic [1:0]      Step
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

  localparam logic [3:0] c_OP_MV  = 4'b0000;
  localparam logic [3:0] c_OP_MVI = 4'b0001;
  localparam logic [3:0] c_OP_ADD = 4'b0010;
  localparam logic [3:0] c_OP_SUB = 4'b0011;
  localparam logic [3:0] c_OP_AND = 4'b0100;
  localparam logic [3:0] c_OP_OR  = 4'b0101;
  localparam logic [3:0] c_OP_XOR = 4'b0110;

  localparam logic [2:0] c_ALU_ADD = 3'b000;
  localparam logic [2:0] c_ALU_SUB = 3'b001;
  localparam logic [2:0] c_ALU_AND = 3'b010;
  localparam logic [2:0] c_ALU_OR  = 3'b011;
  localparam logic [2:0] c_ALU_XOR = 3'b100;

  step_t r_step;
  step_t w_next;

  logic [3:0]      w_opcode;
  logic [2:0]      w_x;
  logic [2:0]      w_y;
  logic [NREG-1:0] w_x_oh;
  logic [NREG-1:0] w_y_oh;
  logic            w_is_alu;
  logic [2:0]      w_alu_fn;

  logic            w_irin;
  logic [NREG-1:0] w_rin;
  logic [NREG-1:0] w_rout;
  logic            w_dinout;
  logic            w_gout;
  logic            w_ain;
  logic            w_gin;
  logic [2:0]      w_aluop;
  logic            w_done;

  function automatic logic [NREG-1:0] onehot(input logic [2:0] idx);
    logic [NREG-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  assign w_opcode = IR[9:6];
  assign w_x      = IR[5:3];
  assign w_y      = IR[2:0];
  assign w_x_oh   = onehot(w_x);
  assign w_y_oh   = onehot(w_y);

  // ALU-class opcodes share the T1..T3 sequence; only the T2 function differs.
  always_comb begin
    w_is_alu = 1'b0;
    w_alu_fn = c_ALU_ADD;
    case (w_opcode)
      c_OP_ADD: begin w_is_alu = 1'b1; w_alu_fn = c_ALU_ADD; end
      c_OP_SUB: begin w_is_alu = 1'b1; w_alu_fn = c_ALU_SUB; end
`ifdef PROC_EXT_ALU_OPS_EN
      c_OP_AND: begin w_is_alu = 1'b1; w_alu_fn = c_ALU_AND; end
      c_OP_OR:  begin w_is_alu = 1'b1; w_alu_fn = c_ALU_OR;  end
      c_OP_XOR: begin w_is_alu = 1'b1; w_alu_fn = c_ALU_XOR; end
`else
      c_OP_AND, c_OP_OR, c_OP_XOR: begin
        w_is_alu = 1'b0;
        w_alu_fn = c_ALU_ADD;
      end
`endif
      default: begin
        w_is_alu = 1'b0;
        w_alu_fn = c_ALU_ADD;
      end
    endcase
  end

  always_comb begin
    w_next   = T0;
    w_irin   = 1'b0;
    w_rin    = '0;
    w_rout   = '0;
    w_dinout = 1'b0;
    w_gout   = 1'b0;
    w_ain    = 1'b0;
    w_gin    = 1'b0;
    w_aluop  = c_ALU_ADD;
    w_done   = 1'b0;

    // Reset masks every control, including the IR load enable.
    if (!reset) begin
      case (r_step)
        T0: begin
          w_irin = Run;
          w_next = Run ? T1 : T0;
        end
        T1: begin
          if (w_opcode == c_OP_MV) begin
            w_rout = w_y_oh;
            w_rin  = w_x_oh;
            w_done = 1'b1;
          end else if (w_opcode == c_OP_MVI) begin
            w_dinout = 1'b1;
            w_rin    = w_x_oh;
            w_done   = 1'b1;
          end else if (w_is_alu) begin
            w_rout = w_x_oh;
            w_ain  = 1'b1;
            w_next = T2;
          end else begin
            w_done = 1'b1;
          end
        end
        T2: begin
          if (w_is_alu) begin
            w_rout  = w_y_oh;
            w_gin   = 1'b1;
            w_aluop = w_alu_fn;
            w_next  = T3;
          end
        end
        T3: begin
          w_gout = 1'b1;
          w_rin  = w_x_oh;
          w_done = 1'b1;
        end
        default: w_next = T0;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      r_step <= T0;
    end else begin
      r_step <= w_next;
    end
  end

  assign IRin   = w_irin;
  assign Rin    = w_rin;
  assign Rout   = w_rout;
  assign DINout = w_dinout;
  assign Gout   = w_gout;
  assign Ain    = w_ain;
  assign Gin    = w_gin;
  assign AluOp  = w_aluop;
  assign Done   = w_done;
  assign Step   = reset ? 2'd0 : r_step;

endmodule

`default_nettype wire

// File: tb/tb_proc_control_fsm.sv
// Bench for proc_control_fsm: directed steps plus random instructions,
// compared cycle by cycle against an instruction-level expectation list.
`default_nettype none

module tb_proc_control_fsm;

  logic       Clock = 1'b0;
  logic       reset;
  logic       Run;
  logic [9:0] IR;
  logic       IRin;
  logic [7:0] Rin;
  logic [7:0] Rout;
  logic       DINout;
  logic       Gout;
  logic       Ain;
  logic       Gin;
  logic [2:0] AluOp;
  logic       Done;
  logic [1:0] Step;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       irin;
    logic [7:0] rin;
    logic [7:0] rout;
    logic       dinout;
    logic       gout;
    logic       ain;
    logic       gin;
    logic [2:0] aluop;
    logic       done;
    logic [1:0] step;
  } outv_t;

  outv_t body[$];

  proc_control_fsm #(.n(10), .NREG(8)) dut (
    .Clock (Clock),
    .reset (reset),
    .Run   (Run),
    .IR    (IR),
    .IRin  (IRin),
    .Rin   (Rin),
    .Rout  (Rout),
    .DINout(DINout),
    .Gout  (Gout),
    .Ain   (Ain),
    .Gin   (Gin),
    .AluOp (AluOp),
    .Done  (Done),
    .Step  (Step)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input outv_t e);
    outv_t o;
    o = {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AluOp, Done, Step};
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  function automatic bit ext_enabled();
`ifdef PROC_EXT_ALU_OPS_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Instruction-level model: list the post-T0 cycles an instruction produces.
  task automatic build(input logic [3:0] op, input logic [2:0] x, input logic [2:0] y);
    outv_t e;
    bit    alu;
    alu = (op == 4'd2) || (op == 4'd3) || (ext_enabled() && op >= 4'd4 && op <= 4'd6);
    body.delete();
    if (op == 4'd0) begin
      e = '0; e.rout = 8'(1) << y; e.rin = 8'(1) << x; e.done = 1; e.step = 1;
      body.push_back(e);
    end else if (op == 4'd1) begin
      e = '0; e.dinout = 1; e.rin = 8'(1) << x; e.done = 1; e.step = 1;
      body.push_back(e);
    end else if (alu) begin
      e = '0; e.rout = 8'(1) << x; e.ain = 1; e.step = 1;
      body.push_back(e);
      e = '0; e.rout = 8'(1) << y; e.gin = 1; e.aluop = 3'(op - 4'd2); e.step = 2;
      body.push_back(e);
      e = '0; e.gout = 1; e.rin = 8'(1) << x; e.done = 1; e.step = 3;
      body.push_back(e);
    end else begin
      e = '0; e.done = 1; e.step = 1;
      body.push_back(e);
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge Clock);
      Run = 1'b0;
      IR  = 10'($urandom);
      #1 check("idle", '0);
    end
  endtask

  task automatic exec(input logic [3:0] op, input logic [2:0] x, input logic [2:0] y);
    outv_t e;
    build(op, x, y);
    @(negedge Clock);
    Run = 1'b1;
    IR  = {op, x, y};
    e = '0; e.irin = 1;
    #1 check($sformatf("T0 op%0d", op), e);
    for (int i = 0; i < body.size(); i++) begin
      @(negedge Clock);
      Run = 1'($urandom);
      #1 check($sformatf("T%0d op%0d x%0d y%0d", i + 1, op, x, y), body[i]);
    end
  endtask

  initial begin
    outv_t e;
    reset = 1'b1;
    Run   = 1'b0;
    IR    = '0;

    // Reset holds every output low, even with Run requested.
    for (int i = 0; i < 2; i++) begin
      @(negedge Clock);
      Run = 1'b1;
      #1 check("reset", '0);
    end
    @(negedge Clock);
    reset = 1'b0;
    Run   = 1'b0;
    #1 check("post-reset", '0);
    idle(5);

    exec(4'b0001, 3'd3, 3'd0);   // mvi R3
    idle(1);
    exec(4'b0000, 3'd5, 3'd1);   // mv R5,R1
    idle(1);
    exec(4'b0011, 3'd1, 3'd2);   // sub R1,R2
    exec(4'b0010, 3'd2, 3'd2);   // add R2,R2 back-to-back
    idle(1);

    // add R0,R7 aborted by reset during T2
    build(4'b0010, 3'd0, 3'd7);
    @(negedge Clock);
    Run = 1'b1;
    IR  = {4'b0010, 3'd0, 3'd7};
    e = '0; e.irin = 1;
    #1 check("abort T0", e);
    @(negedge Clock);
    Run = 1'b0;
    #1 check("abort T1", body[0]);
    @(negedge Clock);
    reset = 1'b1;
    #1 check("abort reset", '0);
    @(negedge Clock);
    reset = 1'b0;
    #1 check("abort after", '0);
    exec(4'b0001, 3'd6, 3'd0);   // mvi R6 after abort
    idle(1);

    exec(4'b0101, 3'd4, 3'd6);   // or R4,R6
    exec(4'b0100, 3'd7, 3'd0);
    exec(4'b0110, 3'd1, 3'd3);
    exec(4'b1111, 3'd2, 3'd5);   // undefined
    idle(1);

    for (int k = 0; k < 60; k++) begin
      exec(4'($urandom), 3'($urandom), 3'($urandom));
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/proc_control_fsm.md
Name: proc_control_fsm

Overview:
- Control unit for the simple synchronous-execution processor. Sits directly downstream of the instruction register and decodes its 10-bit output.
- Sequences the time steps T0–T3 and drives every bus, register-enable and ALU control for one instruction, then asserts Done.
- Also drives IRin, the load enable of the instruction register that feeds it.

Parameters:
- n, 10, instruction width. Field layout is fixed for n=10: opcode IR[9:6], X IR[5:3], Y IR[2:0].
- NREG, 8, number of general registers. Sets the width of the one-hot Rin/Rout buses.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; forces step to T0.
- Run    input  1  start request; sampled only in T0.
- IR     input  n  current instruction from the instruction register; valid from T1 onward.
- IRin   output 1  load enable for the instruction register.
- Rin    output NREG  one-hot write enable for R0..R7.
- Rout   output NREG  one-hot bus-drive select for R0..R7.
- DINout output 1  drive external data DIN onto the bus.
- Gout   output 1  drive ALU result register G onto the bus.
- Ain    output 1  load ALU operand register A from the bus.
- Gin    output 1  load G from the ALU.
- AluOp  output 3  ALU function: 000 add, 001 sub, 010 and, 011 or, 100 xor.
- Done   output 1  last step of the instruction.
- Step   output 2  current time step (0=T0 … 3=T3), for debug and bench use.

Behaviour:
- State: 2-bit step register, T0..T3. Outputs are combinational from step, Run and IR.
- reset=1 at a rising edge:
  - step <= T0 regardless of current step (reset mid-instruction aborts it).
  - While reset=1, all outputs are forced to 0, including IRin. Step reads 0.
- T0:
  - IRin = Run. If Run=1, next step is T1; otherwise stay in T0.
  - All other outputs are 0.
  - IR is loaded on the same edge that leaves T0.
- Run is ignored in T1–T3.
- Decode in T1–T3: X = IR[5:3] and Y = IR[2:0], each expanded to one-hot over NREG.
- T1 by opcode:
  - 0000 mv: Rout=onehot(Y), Rin=onehot(X), Done=1.
  - 0001 mvi: DINout=1, Rin=onehot(X), Done=1.
  - 0010 add, 0011 sub (and extended ops): Rout=onehot(X), Ain=1; next step T2.
  - Undefined opcode: Done=1, no enables asserted, no register written.
- T2 (ALU ops): Rout=onehot(Y), Gin=1, AluOp per opcode; next step T3.
- T3 (ALU ops): Gout=1, Rin=onehot(X), Done=1.
- After any step with Done=1, next step is T0. Done is high for exactly one cycle per instruction.
- Latency:
  - mv/mvi take 2 cycles including T0.
  - ALU ops take 4 cycles.
  - Back-to-back with Run held high: the next T0 immediately follows Done.
- X=Y is legal (e.g. add R2,R2). Rout and Rin may name the same register in the same cycle for mv; the register file handles it.
- At most one of Rout, DINout, Gout is nonzero in any cycle.
- AluOp=000 in every cycle except T2.
- The step counter never wraps: T3 always returns to T0. An unreachable step value also returns to T0.

Optional Feature:
- Macro: PROC_EXT_ALU_OPS_EN.
- Defined: opcodes 0100 and, 0101 or, 0110 xor follow the ALU sequence, with AluOp 010, 011 and 100 respectively in T2.
- Undefined: 0100–0110 are treated as undefined opcodes (Done in T1, no writes), and AluOp only ever takes 000/001.
- Opcodes 0111–1111 are undefined in both builds.

Test Plan:
- Reset and idle: reset=1 for 2 cycles, then Run=0 for 5 cycles -> Step=0 throughout, IRin=0, every other output 0.
- mvi R3: Run=1 in T0, IR=10'b0001_011_000 -> T0: IRin=1. T1: DINout=1, Rin=8'b0000_1000, Done=1. Next cycle Step=0.
- mv R5,R1: IR=10'b0000_101_001 -> T1: Rout=8'b0000_0010, Rin=8'b0010_0000, Done=1. Total 2 cycles.
- sub R1,R2: IR=10'b0011_001_010 ->
  - T1: Rout=8'b0000_0010, Ain=1.
  - T2: Rout=8'b0000_0100, Gin=1, AluOp=001.
  - T3: Gout=1, Rin=8'b0000_0010, Done=1.
- Reset mid-op: add R0,R7 with reset=1 during T2 -> next cycle Step=0, no Gout/Rin/Done asserted. A following mvi then executes normally.
- Opcode 0101 (or R4,R6):
  - With PROC_EXT_ALU_OPS_EN defined -> T2 AluOp=011, T3 Rin=8'b0001_0000.
  - Without the macro -> T1 Done=1, Rin=0, back to T0.
